dmem_axi_bridge: RTL
====================

DMEM_AXI_BRIDGE -- requirements
Module: dmem_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1: ID driven on arid/awid.
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 req  in  1  request from MMU-side data port; held until addr_ok.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 addr  in  32  physical address.
REQ-007 size  in  2  0 = byte, 1 = half, 2 = word.
REQ-008 wstrb  in  4  store byte enables.
REQ-009 wdata  in  32  store data, already lane-replicated.
REQ-010 addr_ok  out  1  request accepted this cycle.
REQ-011 data_ok  out  1  one-cycle pulse: transaction complete.
REQ-012 rdata  out  32  raw load word, valid with data_ok on loads.
REQ-013 AXI read: araddr out 32, arsize out 3, arvalid out 1, arready in 1; rdata_i in 32, rvalid in 1, rready out 1 (rid/rresp/rlast in, ignored).
REQ-014 AXI write: awaddr out 32, awsize out 3, awvalid out 1, awready in 1; wdata_o out 32, wstrb_o out 4, wvalid out 1, wready in 1; bvalid in 1, bready out 1 (bid/bresp in, ignored).
REQ-015 Constant outputs: arid=awid=AXI_ID, arlen=awlen=8'd0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wid=AXI_ID, wlast=1.

Function
REQ-016 States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; one transaction outstanding at most.
REQ-017 addr_ok = req && state==IDLE; no other state asserts addr_ok.
REQ-018 On addr_ok, register addr, size, wstrb, wdata; next state RD_ADDR if !we, else WR_REQ.
REQ-019 arsize/awsize = {1'b0, size_reg}; araddr/awaddr = addr_reg.
REQ-020 RD_ADDR: arvalid=1; on arready go RD_DATA; arvalid low from the next cycle.
REQ-021 RD_DATA: rready=1; on rvalid: data_ok=1, rdata=rdata_i (combinational pass-through), next state IDLE.
REQ-022 WR_REQ: awvalid = !aw_done, wvalid = !w_done; aw_done set on awvalid&&awready, w_done set on wvalid&&wready; handshakes may occur in either order or the same cycle.
REQ-023 WR_REQ exits to WR_RESP in the cycle both handshakes are complete (including completing this cycle); aw_done/w_done clear on exit.
REQ-024 WR_RESP: bready=1; on bvalid: data_ok=1, next state IDLE; rdata don't-care.
REQ-025 data_ok is never asserted outside RD_DATA/WR_RESP and never in two consecutive cycles.
REQ-026 Earliest new request accept is the cycle after data_ok (IDLE reached); req during busy states is ignored and must stay held by requester.
REQ-027 rresp/bresp errors are not reported; the transaction completes normally.
REQ-028 arvalid/awvalid/wvalid, once asserted, stay asserted with stable payload until their handshake.

Reset
REQ-029 resetn=0 at posedge: state=IDLE, aw_done=w_done=0; arvalid, awvalid, wvalid, rready, bready, data_ok all 0 the following cycle; addr_ok follows REQ-017 combinationally after reset.
REQ-030 Reset mid-transaction abandons it without data_ok; the AXI slave is reset together with the bridge.
REQ-031 Captured request registers need not be reset.

Verification
REQ-032 Load word 0x1C00_0100, arready=1 immediately, rvalid 3 cycles later with 0xDEAD_BEEF -> addr_ok cycle 0, arvalid cycle 1, data_ok=1 and rdata=0xDEAD_BEEF same cycle as rvalid, addr_ok available the next cycle.
REQ-033 Byte store addr 0x...03, wstrb 4'b1000, wdata 0x5A5A_5A5A; wready cycle 1, awready cycle 3 -> wvalid drops after cycle 1, awvalid held until cycle 3, arsize/awsize=0, WR_RESP from cycle 4, data_ok on bvalid.
REQ-034 awready and wready high together in first WR_REQ cycle -> WR_RESP next cycle, one data_ok per bvalid.
REQ-035 req held high continuously with new payload after each data_ok -> exactly one addr_ok per transaction, none while busy, no overlapping AXI transactions.
REQ-036 resetn=0 in RD_DATA before rvalid -> next cycle IDLE, rready=0, no data_ok; a following req gets addr_ok immediately.
REQ-037 bresp=2'b10 on a store -> data_ok still pulses once; state returns to IDLE.

Source files
------------

// File: rtl/dmem_axi_bridge.sv
// Bridges a single-outstanding SRAM-like data port (req/addr_ok/data_ok) onto an
// AXI3 master with single-beat reads and writes.
module dmem_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // MMU-side data port
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    // AXI read address / data
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_done_nxt;
    logic        w_w_done_nxt;
    logic        w_aw_fire;
    logic        w_w_fire;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    // Response IDs, codes and rlast carry nothing a single-beat bridge needs.
    logic        w_unused;
    assign w_unused = &{1'b0, rid, rresp, rlast, bid, bresp};

    assign addr_ok   = req && (r_state == IDLE);
    assign arvalid   = (r_state == RD_ADDR);
    assign rready    = (r_state == RD_DATA);
    assign awvalid   = (r_state == WR_REQ) && !r_aw_done;
    assign wvalid    = (r_state == WR_REQ) && !r_w_done;
    assign bready    = (r_state == WR_RESP);
    assign data_ok   = ((r_state == RD_DATA) && rvalid) || ((r_state == WR_RESP) && bvalid);
    assign rdata     = rdata_i;

    assign w_aw_fire = awvalid && awready;
    assign w_w_fire  = wvalid && wready;

    assign araddr    = r_addr;
    assign awaddr    = r_addr;
    assign arsize    = {1'b0, r_size};
    assign awsize    = {1'b0, r_size};
    assign wdata_o   = r_wdata;
    assign wstrb_o   = r_wstrb;

    assign arid      = AXI_ID;
    assign awid      = AXI_ID;
    assign wid       = AXI_ID;
    assign arlen     = 8'd0;
    assign awlen     = 8'd0;
    assign arburst   = 2'b01;
    assign awburst   = 2'b01;
    assign arlock    = 2'b00;
    assign awlock    = 2'b00;
    assign arcache   = 4'd0;
    assign awcache   = 4'd0;
    assign arprot    = 3'd0;
    assign awprot    = 3'd0;
    assign wlast     = 1'b1;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        unique case (r_state)
            IDLE: begin
                if (addr_ok) begin
                    w_state_nxt = we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                w_aw_done_nxt = r_aw_done || w_aw_fire;
                w_w_done_nxt  = r_w_done || w_w_fire;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt   = WR_RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed after being loaded on addr_ok.
    always_ff @(posedge clk) begin
        if (addr_ok) begin
            r_addr  <= addr;
            r_size  <= size;
            r_wstrb <= wstrb;
            r_wdata <= wdata;
        end
    end

endmodule
